// File: rtl/dilated_causal_1d_deconv.sv
// Inverse dilated causal deconvolution with one shared multiplier; x_hat is valid K-1 edges after the accepting edge.
// A stalled output holds out_data with in_ready low; DECONV_SAT_FLAG_EN adds sat_flag and sat_count.
module dilated_causal_1d_deconv #(
    parameter int DILATION    = 2,
    parameter int KERNEL_SIZE = 3,
    parameter int ACC_W       = 20,
    localparam int CW         = $clog2(KERNEL_SIZE)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [7:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [7:0]   out_data,
    input  logic                coef_we,
    input  logic [CW-1:0]       coef_addr,
    input  logic signed [7:0]   coef_data
`ifdef DECONV_SAT_FLAG_EN
    ,
    output logic                sat_flag,
    output logic [15:0]         sat_count
`endif
);

    localparam int L  = DILATION * (KERNEL_SIZE - 1);
    localparam int HW = (L > 1) ? $clog2(L) : 1;
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-128);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic [CW-1:0]           k;
    logic [HW-1:0]           wptr;
    logic signed [7:0]       hist [0:L-1];
    logic signed [7:0]       h    [1:KERNEL_SIZE-1];

    logic [HW-1:0]           rd_addr;
    int                      rd_pos;
    logic signed [15:0]      prod;
    logic signed [ACC_W-1:0] acc_mac;
    logic signed [7:0]       acc_sat;
    logic                    last_tap;

    function automatic logic signed [7:0] sat8(input logic signed [ACC_W-1:0] v);
        if (v > SAT_HI)
            return 8'sd127;
        else if (v < SAT_LO)
            return -8'sd128;
        else
            return v[7:0];
    endfunction

    // Lag k*D lands at (wptr - k*D) mod L; lag L is the oldest slot, at wptr itself.
    always_comb begin
        rd_pos = int'(wptr) - int'(k) * DILATION;
        if (rd_pos < 0)
            rd_pos = rd_pos + L;
        rd_addr = rd_pos[HW-1:0];
    end

    assign prod     = h[k] * hist[rd_addr];
    assign acc_mac  = acc - {{(ACC_W-16){prod[15]}}, prod};
    assign acc_sat  = sat8(acc_mac);
    assign last_tap = (int'(k) == KERNEL_SIZE - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            acc       <= '0;
            k         <= CW'(1);
            wptr      <= '0;
            for (int i = 0; i < L; i++)
                hist[i] <= '0;
            for (int i = 1; i < KERNEL_SIZE; i++)
                h[i] <= 8'(i + 1);
        end else begin
            case (state)
                IDLE: begin
                    if (coef_we && coef_addr != '0 && int'(coef_addr) < KERNEL_SIZE)
                        h[coef_addr] <= coef_data;
                    if (in_valid) begin
                        acc      <= {{(ACC_W-8){in_data[7]}}, in_data};
                        k        <= CW'(1);
                        in_ready <= 1'b0;
                        state    <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_mac;
                    if (last_tap) begin
                        // The only history write per sample happens here, so a stall in OUT cannot repeat it.
                        out_valid     <= 1'b1;
                        out_data      <= acc_sat;
                        hist[wptr]    <= acc_sat;
                        wptr          <= (wptr == HW'(L - 1)) ? '0 : wptr + HW'(1);
                        state         <= OUT;
                    end else begin
                        k <= k + CW'(1);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef DECONV_SAT_FLAG_EN
    logic mac_clip;
    assign mac_clip = (acc_mac > SAT_HI) || (acc_mac < SAT_LO);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_flag  <= 1'b0;
            sat_count <= '0;
        end else if (state == MAC && last_tap) begin
            sat_flag <= mac_clip;
            if (mac_clip && sat_count != 16'hFFFF)
                sat_count <= sat_count + 16'd1;
        end else if (state == OUT && out_ready) begin
            sat_flag <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_dilated_causal_1d_deconv.sv
// Directed bench for dilated_causal_1d_deconv at D=2, K=3 with hand-computed x_hat sequences.
module tb_dilated_causal_1d_deconv;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_data;
    logic              coef_we;
    logic [1:0]        coef_addr;
    logic signed [7:0] coef_data;
`ifdef DECONV_SAT_FLAG_EN
    logic              sat_flag;
    logic [15:0]       sat_count;
`endif

    int                total = 0;
    int                bad   = 0;
    int                lat;
    logic signed [7:0] got;

    // x_hat[n] = y[n] - 2*x_hat[n-2] - 3*x_hat[n-4]
    logic signed [7:0] imp_x [0:8] = '{8'sd1, 8'sd0, -8'sd2, 8'sd0, 8'sd1, 8'sd0, 8'sd4, 8'sd0, -8'sd11};
    // y = forward conv of x with h = 1,2,3 at D = 2
    logic signed [7:0] rt_y  [0:4] = '{8'sd5, -8'sd3, 8'sd17, -8'sd6, 8'sd31};
    logic signed [7:0] rt_x  [0:4] = '{8'sd5, -8'sd3, 8'sd7, 8'sd0, 8'sd2};
    logic signed [7:0] cw_x  [0:4] = '{8'sd1, 8'sd0, 8'sd0, 8'sd0, -8'sd3};

    always #5 clk = ~clk;

    dilated_causal_1d_deconv #(
        .DILATION   (2),
        .KERNEL_SIZE(3),
        .ACC_W      (20)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .coef_we  (coef_we),
        .coef_addr(coef_addr),
        .coef_data(coef_data)
`ifdef DECONV_SAT_FLAG_EN
        ,
        .sat_flag (sat_flag),
        .sat_count(sat_count)
`endif
    );

    task automatic check(input string tag, input logic signed [16:0] obs, input logic signed [16:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic accept(input logic signed [7:0] y);
        int n = 0;
        in_data  = y;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("in_ready_wait", {16'b0, in_ready}, 17'sd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // lat counts edges after the accepting edge until out_valid is seen.
    task automatic wait_out(output logic signed [7:0] d);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("out_valid_wait", {16'b0, out_valid}, 17'sd1);
        d = out_data;
    endtask

    task automatic send(input logic signed [7:0] y, output logic signed [7:0] d);
        accept(y);
        wait_out(d);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state and impulse response with default coefficients
        do_reset();
        check("rst_in_ready", {16'b0, in_ready}, 17'sd1);
        check("rst_out_valid", {16'b0, out_valid}, 17'sd0);
        check("rst_out_data", out_data, 17'sd0);
        accept(8'sd1);
        wait_out(got);
        // Third cycle counting the accepting one is two edges after the accepting edge.
        check("latency_edges", 17'(lat), 17'sd2);
        check("imp0", got, imp_x[0]);
        @(posedge clk);
        #1;
        for (int i = 1; i < 9; i++) begin
            send(8'sd0, got);
            check($sformatf("imp%0d", i), got, imp_x[i]);
        end

        // Round trip through the forward convolution
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(rt_y[i], got);
            check($sformatf("rt%0d", i), got, rt_x[i]);
        end

        // Saturation with h1 = 100: raw 12800 clips to 127
        do_reset();
        coef_we   = 1'b1;
        coef_addr = 2'd1;
        coef_data = 8'sd100;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        send(-8'sd128, got);
        check("sat0", got, -17'sd128);
        send(8'sd0, got);
        check("sat1", got, 17'sd0);
        accept(8'sd0);
        wait_out(got);
        check("sat2", got, 17'sd127);
`ifdef DECONV_SAT_FLAG_EN
        check("sat_flag", {16'b0, sat_flag}, 17'sd1);
        check("sat_count", {1'b0, sat_count}, 17'sd1);
`endif
        @(posedge clk);
        #1;

        // Backpressure: output held, input blocked, single history write
        do_reset();
        out_ready = 1'b0;
        accept(8'sd1);
        wait_out(got);
        check("bp_first", got, 17'sd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_hold_data%0d", i), out_data, 17'sd1);
            check($sformatf("bp_hold_valid%0d", i), {16'b0, out_valid}, 17'sd1);
            check($sformatf("bp_in_ready%0d", i), {16'b0, in_ready}, 17'sd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", {16'b0, out_valid}, 17'sd0);
        check("bp_release_ready", {16'b0, in_ready}, 17'sd1);
        for (int i = 1; i < 5; i++) begin
            send(8'sd0, got);
            check($sformatf("bp_after%0d", i), got, imp_x[i]);
        end

        // Coefficient write during MAC is dropped
        do_reset();
        accept(8'sd1);
        coef_we   = 1'b1;
        coef_addr = 2'd1;
        coef_data = 8'sd0;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        wait_out(got);
        check("cmac0", got, imp_x[0]);
        @(posedge clk);
        #1;
        for (int i = 1; i < 3; i++) begin
            send(8'sd0, got);
            check($sformatf("cmac%0d", i), got, imp_x[i]);
        end

        // Same write in IDLE, together with the first in_valid, takes effect
        do_reset();
        coef_we   = 1'b1;
        coef_addr = 2'd1;
        coef_data = 8'sd0;
        accept(8'sd1);
        coef_we = 1'b0;
        wait_out(got);
        check("cidle0", got, cw_x[0]);
        @(posedge clk);
        #1;
        for (int i = 1; i < 5; i++) begin
            send(8'sd0, got);
            check($sformatf("cidle%0d", i), got, cw_x[i]);
        end

        // Reset in the middle of MAC discards the partial sample
        do_reset();
        send(8'sd1, got);
        check("rmid_pre0", got, 17'sd1);
        send(8'sd0, got);
        check("rmid_pre1", got, 17'sd0);
        accept(8'sd7);
        reset = 1'b1;
        #2;
        check("rmid_out_valid", {16'b0, out_valid}, 17'sd0);
        check("rmid_in_ready", {16'b0, in_ready}, 17'sd1);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send((i == 0) ? 8'sd1 : 8'sd0, got);
            check($sformatf("rmid_post%0d", i), got, imp_x[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
